// File: rtl/multi_counter_pkg.sv
// Shared register map, CTRL/STATUS bit positions and the byte-lane merge helper
// for the multi_counter block.
package multi_counter_pkg;

    typedef enum logic [1:0] {
        REG_CTRL   = 2'd0,
        REG_COUNT  = 2'd1,
        REG_LIMIT  = 2'd2,
        REG_STATUS = 2'd3
    } reg_sel_e;

    localparam int unsigned CTRL_EN      = 0;
    localparam int unsigned CTRL_DOWN    = 1;
    localparam int unsigned CTRL_ONESHOT = 2;
    localparam int unsigned CTRL_IRQ_EN  = 3;
    localparam int unsigned CTRL_BITS    = 4;

    localparam int unsigned STATUS_MATCH = 0;

    localparam int unsigned CHANNEL_STRIDE = 16;

    // Replace only the byte lanes selected by strb; other lanes keep old_val.
    function automatic logic [31:0] apply_wstrb(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  strb);
        logic [31:0] merged;
        merged = old_val;
        for (int unsigned b = 0; b < 4; b++) begin
            if (strb[b]) begin
                merged[8*b +: 8] = new_val[8*b +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/counter_channel.sv
// One counter channel: CTRL/COUNT/LIMIT/MATCH registers, tick, wrap and oneshot
// behaviour, plus the level interrupt.
module counter_channel
    import multi_counter_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 wr_en,
    input  reg_sel_e             wr_reg,
    input  logic [31:0]          wr_data,
    input  logic [3:0]           wr_strb,
    output logic [CTRL_BITS-1:0] ctrl,
    output logic [WIDTH-1:0]     count,
    output logic [WIDTH-1:0]     limit,
    output logic                 match,
    output logic                 irq
);

    logic [CTRL_BITS-1:0] ctrl_q,  ctrl_d;
    logic [WIDTH-1:0]     count_q, count_d;
    logic [WIDTH-1:0]     limit_q, limit_d;
    logic                 match_q, match_d;

    logic        tick_hit;
    logic        match_clr;
    logic [31:0] wide;

    always_comb begin
        ctrl_d    = ctrl_q;
        count_d   = count_q;
        limit_d   = limit_q;
        tick_hit  = 1'b0;
        match_clr = 1'b0;
        wide      = '0;

        if (ctrl_q[CTRL_EN]) begin
            if (!ctrl_q[CTRL_DOWN]) begin
                if (count_q == limit_q) begin
                    tick_hit = 1'b1;
                    if (ctrl_q[CTRL_ONESHOT]) begin
                        ctrl_d[CTRL_EN] = 1'b0;
                        count_d         = limit_q;
                    end else begin
                        count_d = '0;
                    end
                end else begin
                    count_d = count_q + WIDTH'(1);
                end
            end else begin
                if (count_q == '0) begin
                    tick_hit = 1'b1;
                    if (ctrl_q[CTRL_ONESHOT]) begin
                        ctrl_d[CTRL_EN] = 1'b0;
                        count_d         = '0;
                    end else begin
                        count_d = limit_q;
                    end
                end else begin
                    count_d = count_q - WIDTH'(1);
                end
            end
        end

        if (wr_en) begin
            case (wr_reg)
                REG_CTRL: begin
                    wide[CTRL_BITS-1:0] = ctrl_q;
                    wide                = apply_wstrb(wide, wr_data, wr_strb);
                    ctrl_d              = wide[CTRL_BITS-1:0];
                end
                REG_COUNT: begin
                    // A colliding COUNT write discards the tick's match event,
                    // including the oneshot disable that would go with it.
                    wide[WIDTH-1:0] = count_q;
                    wide            = apply_wstrb(wide, wr_data, wr_strb);
                    count_d         = wide[WIDTH-1:0];
                    ctrl_d          = ctrl_q;
                    tick_hit        = 1'b0;
                end
                REG_LIMIT: begin
                    wide[WIDTH-1:0] = limit_q;
                    wide            = apply_wstrb(wide, wr_data, wr_strb);
                    limit_d         = wide[WIDTH-1:0];
                end
                REG_STATUS: begin
                    match_clr = wr_strb[0] && wr_data[STATUS_MATCH];
                end
            endcase
        end

        match_d = (match_q && !match_clr) || tick_hit;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_q  <= '0;
            count_q <= '0;
            limit_q <= '0;
            match_q <= 1'b0;
        end else begin
            ctrl_q  <= ctrl_d;
            count_q <= count_d;
            limit_q <= limit_d;
            match_q <= match_d;
        end
    end

    assign ctrl  = ctrl_q;
    assign count = count_q;
    assign limit = limit_q;
    assign match = match_q;
    assign irq   = match_q & ctrl_q[CTRL_IRQ_EN];

endmodule

// File: rtl/multi_counter.sv
// Bank of independent counters behind a simple valid/ready register bus:
// address decode, one-cycle ready handshake and registered read mux.
module multi_counter
    import multi_counter_pkg::*;
#(
    parameter int unsigned CHANNELS  = 4,
    parameter int unsigned WIDTH     = 32,
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      valid,
    input  logic [3:0]                wstrb,
    input  logic [31:0]               addr,
    input  logic [31:0]               wdata,
    output logic                      ready,
    output logic [31:0]               rdata,
    output logic [CHANNELS*WIDTH-1:0] count_o,
    output logic [CHANNELS-1:0]       irq
);

    localparam int unsigned CH_LSB = $clog2(CHANNEL_STRIDE);

    logic        ready_q, ready_d;
    logic [31:0] rdata_q, rdata_d;

    logic        hit;
    logic        accept;
    logic        is_write;
    logic [3:0]  ch_idx;
    reg_sel_e    reg_sel;
    logic [31:0] rd_val;
    logic        unused_addr_bits;

    logic [CTRL_BITS-1:0] ch_ctrl  [CHANNELS];
    logic [WIDTH-1:0]     ch_count [CHANNELS];
    logic [WIDTH-1:0]     ch_limit [CHANNELS];
    logic [CHANNELS-1:0]  ch_match;

    assign hit              = (addr[31:8] == BASE_ADDR[31:8]);
    assign ch_idx           = addr[CH_LSB +: 4];
    assign reg_sel          = reg_sel_e'(addr[3:2]);
    assign is_write         = |wstrb;
    assign accept           = valid && !ready_q && hit;
    assign unused_addr_bits = ^addr[1:0];

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        logic wr_en;
        assign wr_en = accept && is_write && (ch_idx == 4'(g));

        counter_channel #(
            .WIDTH (WIDTH)
        ) u_channel (
            .clk     (clk),
            .reset   (reset),
            .wr_en   (wr_en),
            .wr_reg  (reg_sel),
            .wr_data (wdata),
            .wr_strb (wstrb),
            .ctrl    (ch_ctrl[g]),
            .count   (ch_count[g]),
            .limit   (ch_limit[g]),
            .match   (ch_match[g]),
            .irq     (irq[g])
        );

        assign count_o[g*WIDTH +: WIDTH] = ch_count[g];
    end

    // Channel indices with no instance fall through and read as zero.
    always_comb begin
        rd_val = '0;
        for (int unsigned n = 0; n < CHANNELS; n++) begin
            if (ch_idx == 4'(n)) begin
                case (reg_sel)
                    REG_CTRL:   rd_val[CTRL_BITS-1:0] = ch_ctrl[n];
                    REG_COUNT:  rd_val[WIDTH-1:0]     = ch_count[n];
                    REG_LIMIT:  rd_val[WIDTH-1:0]     = ch_limit[n];
                    REG_STATUS: rd_val[STATUS_MATCH]  = ch_match[n];
                endcase
            end
        end
    end

    always_comb begin
        ready_d = accept;
        rdata_d = rdata_q;
        if (accept) begin
            rdata_d = rd_val;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ready_q <= 1'b0;
            rdata_q <= '0;
        end else begin
            ready_q <= ready_d;
            rdata_q <= rdata_d;
        end
    end

    assign ready = ready_q;
    assign rdata = rdata_q;

endmodule

// File: tb/tb_multi_counter.sv
// Directed self-checking bench for multi_counter (CHANNELS=4, WIDTH=32).
module tb_multi_counter;

    localparam logic [31:0] BASE = 32'h3000_0000;

    logic         clk = 1'b0;
    logic         reset;
    logic         valid;
    logic [3:0]   wstrb;
    logic [31:0]  addr;
    logic [31:0]  wdata;
    logic         ready;
    logic [31:0]  rdata;
    logic [127:0] count_o;
    logic [3:0]   irq;

    int n_checks = 0;
    int n_fail   = 0;

    multi_counter #(
        .CHANNELS  (4),
        .WIDTH     (32),
        .BASE_ADDR (BASE)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .valid   (valid),
        .wstrb   (wstrb),
        .addr    (addr),
        .wdata   (wdata),
        .ready   (ready),
        .rdata   (rdata),
        .count_o (count_o),
        .irq     (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] reg_addr(input int ch, input int rg);
        return BASE | (32'(ch) << 4) | (32'(rg) << 2);
    endfunction

    function automatic logic [31:0] cnt(input int ch);
        return count_o[ch*32 +: 32];
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Returns in the ready cycle (1 ns after the edge), with valid dropped.
    task automatic bus(input int ch, input int rg, input logic [31:0] data,
                       input logic [3:0] strb, output logic [31:0] rd, output int lat);
        addr  = reg_addr(ch, rg);
        wdata = data;
        wstrb = strb;
        valid = 1'b1;
        lat   = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!ready && lat < 8);
        check("bus_ready", ready, 1);
        rd    = rdata;
        valid = 1'b0;
        wstrb = 4'h0;
    endtask

    task automatic wr(input int ch, input int rg, input logic [31:0] data);
        logic [31:0] rd;
        int          lat;
        bus(ch, rg, data, 4'hF, rd, lat);
    endtask

    task automatic rd_chk(input string tag, input int ch, input int rg, input logic [31:0] exp);
        logic [31:0] rd;
        int          lat;
        bus(ch, rg, 32'h0, 4'h0, rd, lat);
        check(tag, rd, exp);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        int          lat;
        int          saw;
        logic [31:0] up_seq [5];

        reset = 1'b1;
        valid = 1'b0;
        wstrb = 4'h0;
        addr  = 32'h0;
        wdata = 32'h0;
        tick(3);
        check("rst_ready", ready, 0);
        check("rst_rdata", rdata, 0);
        check("rst_count", count_o, 0);
        check("rst_irq", irq, 0);
        reset = 1'b0;
        tick(1);

        // Up wrap on ch0, LIMIT=3.
        wr(0, 2, 32'd3);
        wr(0, 0, 32'h1);
        check("up_c0", cnt(0), 0);
        up_seq = '{32'd1, 32'd2, 32'd3, 32'd0, 32'd1};
        for (int i = 0; i < 5; i++) begin
            tick(1);
            check("up_seq", cnt(0), up_seq[i]);
        end
        rd_chk("up_match", 0, 3, 32'h1);
        wr(0, 0, 32'h0);
        wr(0, 3, 32'h1);
        rd_chk("up_match_clr", 0, 3, 32'h0);

        // Down oneshot with interrupt on ch1.
        wr(1, 2, 32'd5);
        wr(1, 1, 32'd2);
        wr(1, 0, 32'hF);
        check("dn_c0", cnt(1), 2);
        tick(1);
        check("dn_c1", cnt(1), 1);
        tick(1);
        check("dn_c2", cnt(1), 0);
        check("dn_irq_pre", irq[1], 0);
        tick(1);
        check("dn_c3", cnt(1), 0);
        check("dn_irq_set", irq[1], 1);
        tick(3);
        check("dn_hold", cnt(1), 0);
        rd_chk("dn_ctrl", 1, 0, 32'hE);
        check("dn_irq_hold", irq[1], 1);
        wr(1, 3, 32'h1);
        check("dn_irq_clr", irq[1], 0);
        tick(1);

        // Byte-strobe write on ch2.
        bus(2, 1, 32'hAABB_CCDD, 4'b0101, rd, lat);
        check("strb_lat", lat, 1);
        tick(1);
        check("strb_pulse", ready, 0);
        rd_chk("strb_read", 2, 1, 32'h00BB_00DD);
        check("strb_count_o", cnt(2), 32'h00BB_00DD);
        tick(2);
        check("rdata_hold", rdata, 32'h00BB_00DD);

        // COUNT write colliding with the ch0 limit match.
        wr(0, 1, 32'd0);
        wr(0, 0, 32'h1);
        tick(3);
        check("col_pre", cnt(0), 3);
        wr(0, 1, 32'd7);
        check("col_count", cnt(0), 7);
        rd_chk("col_match", 0, 3, 32'h0);
        wr(0, 0, 32'h0);

        // W1C coinciding with a match on ch3 (LIMIT=2, EN|IRQ_EN).
        wr(3, 2, 32'd2);
        wr(3, 0, 32'h9);
        check("w1c_c0", cnt(3), 0);
        tick(5);
        check("w1c_pre_cnt", cnt(3), 2);
        check("w1c_pre_irq", irq[3], 1);
        wr(3, 3, 32'h1);
        check("w1c_collide", irq[3], 1);
        wr(3, 0, 32'h0);
        wr(3, 3, 32'h1);
        check("w1c_clear", irq[3], 0);
        check("indep_ch2", cnt(2), 32'h00BB_00DD);
        tick(1);

        // Out-of-range channel and non-hit address.
        rd_chk("oor_prime", 2, 1, 32'h00BB_00DD);
        tick(1);
        rd_chk("oor_read", 9, 1, 32'h0);
        wr(9, 1, 32'h55);
        check("oor_wr_ignored", count_o[95:0], {32'h00BB_00DD, 32'd0, 32'd0} | 96'(cnt(0)));
        tick(1);
        addr  = 32'h4000_0024;
        wdata = 32'h1234;
        wstrb = 4'hF;
        valid = 1'b1;
        saw   = 0;
        for (int i = 0; i < 4; i++) begin
            tick(1);
            if (ready) saw = 1;
        end
        valid = 1'b0;
        wstrb = 4'h0;
        check("nohit_ready", saw, 0);
        check("nohit_state", cnt(2), 32'h00BB_00DD);

        // Reset during a pending request.
        addr  = reg_addr(2, 1);
        valid = 1'b1;
        reset = 1'b1;
        tick(1);
        check("rst_mid_ready", ready, 0);
        reset = 1'b0;
        valid = 1'b0;
        saw   = 0;
        for (int i = 0; i < 2; i++) begin
            tick(1);
            if (ready) saw = 1;
        end
        check("rst_mid_noready", saw, 0);
        check("rst_mid_count", count_o, 0);
        check("rst_mid_irq", irq, 0);
        check("rst_mid_rdata", rdata, 0);
        rd_chk("rst_mid_limit", 1, 2, 32'h0);
        rd_chk("rst_mid_ctrl", 1, 0, 32'h0);
        rd_chk("rst_mid_status", 3, 3, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/multi_counter.md
MULTI_COUNTER -- requirements
Module: multi_counter

Interface
REQ-001 Parameter CHANNELS, default 4: number of independent counter channels, range 1..16.
REQ-002 Parameter WIDTH, default 32: counter width in bits, range 8..32.
REQ-003 Parameter BASE_ADDR, default 32'h3000_0000: bus base address; only bits [31:8] are significant.
REQ-004 Port clk, input, 1: clock; all state changes on its rising edge.
REQ-005 Port reset, input, 1: reset, synchronous, active-high.
REQ-006 Port valid, input, 1: bus request strobe.
REQ-007 Port wstrb, input, 4: byte write enables; all zero means read.
REQ-008 Port addr, input, 32: byte address.
REQ-009 Port wdata, input, 32: write data.
REQ-010 Port ready, output, 1: one-cycle acknowledge pulse.
REQ-011 Port rdata, output, 32: registered read data.
REQ-012 Port count_o, output, CHANNELS*WIDTH: live channel counts; channel n occupies bits [n*WIDTH +: WIDTH].
REQ-013 Port irq, output, CHANNELS: per-channel interrupt, level-sensitive.

Function
REQ-014 Address decode: hit when addr[31:8] == BASE_ADDR[31:8].
- Channel index = addr[7:4]; register = addr[3:2].
- Registers: 0 CTRL, 1 COUNT, 2 LIMIT, 3 STATUS.
REQ-015 CTRL bits: [0] EN, [1] DOWN, [2] ONESHOT, [3] IRQ_EN; all other bits read 0.
REQ-016 STATUS bit [0] is the sticky flag MATCH; writing 1 clears it (W1C); other bits read 0.
REQ-017 Handshake: when valid && !ready && hit, ready = 1 on the next cycle for exactly one cycle; the next request is accepted no earlier than the cycle after ready.
REQ-018 A hit whose channel index is >= CHANNELS completes normally: ready pulses, rdata = 0, write is ignored.
REQ-019 With valid and no hit, ready stays 0 and no state changes.
REQ-020 Reads return the pre-write register value in rdata, zero-extended to 32 bits, valid in the ready cycle; rdata holds its value otherwise.
REQ-021 Writes apply per byte lane under wstrb; bits at or above WIDTH are discarded.
REQ-022 Tick: a channel with EN = 1 steps by 1 every cycle.
REQ-023 Up mode (DOWN = 0), when COUNT == LIMIT:
- next COUNT = 0;
- MATCH set;
- if ONESHOT, EN cleared and COUNT holds LIMIT instead of wrapping.
REQ-024 Down mode (DOWN = 1), when COUNT == 0:
- next COUNT = LIMIT;
- MATCH set;
- if ONESHOT, EN cleared and COUNT holds 0.
REQ-025 Otherwise, arithmetic is modulo 2^WIDTH.
REQ-026 irq[n] = MATCH[n] & IRQ_EN[n], combinational from registers.
REQ-027 Simultaneous bus write to COUNT and tick: the bus write wins; no MATCH is generated that cycle.
REQ-028 Simultaneous W1C of MATCH and new match event: MATCH remains set.
REQ-029 A write to CTRL takes effect for ticks from the following cycle.
REQ-030 A write to LIMIT takes effect for ticks from the following cycle.
REQ-031 Channels are fully independent; an access to one channel never alters another.

Reset
REQ-032 On reset, all of the following are 0: COUNT, LIMIT, CTRL, MATCH, ready, rdata, irq.
REQ-033 Reset overrides any in-flight request; no ready is issued for a request pending at reset.

Structure
REQ-034 Package multi_counter_pkg holds:
- register offsets (CTRL/COUNT/LIMIT/STATUS);
- CTRL bit indices;
- STATUS bit index;
- the channel stride (16 bytes).
REQ-035 One sub-module, counter_channel, is instantiated CHANNELS times by generate. It contains the per-channel registers, tick, match and oneshot logic. The top contains decode, handshake and read mux.

Verification
REQ-036 Up wrap: ch0 LIMIT = 3, CTRL = 0x1 -> count_o[ch0] sequence 0,1,2,3,0,1; MATCH set after the 3->0 step.
REQ-037 Down oneshot with IRQ: ch1 LIMIT = 5, COUNT = 2, CTRL = 0xF -> 2,1,0, then holds 0; EN reads 0; irq[1] = 1 until STATUS is written 0x1, then irq[1] = 0.
REQ-038 Byte-strobe write: ch2 COUNT write 0xAABBCCDD with wstrb = 4'b0101 from 0 -> COUNT reads 0x00BB00DD; ready is a single-cycle pulse one cycle after valid.
REQ-039 Collision: write COUNT = 7 in the same cycle ch0 reaches LIMIT -> COUNT = 7, MATCH unchanged. Separately, a W1C coinciding with a match -> MATCH remains 1.
REQ-040 Out-of-range and reset:
- read of channel 9 with CHANNELS = 4 -> ready = 1, rdata = 0;
- reset asserted mid-request -> no ready, all registers 0.
